// File: rtl/yuv422_standard2yuv_pkg.sv
// Shared definitions for the 4:2:2 standard-to-signed YUV unpacker: dtype width,
// chroma offset helper and FSM state encodings.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif

package yuv422_standard2yuv_pkg;

  localparam int META_WIDTH = 16;

  // Position inside the interleaved C0 Y0 C1 Y1 group.
  typedef enum logic [1:0] {
    S_C0 = 2'd0,
    S_Y0 = 2'd1,
    S_C1 = 2'd2,
    S_Y1 = 2'd3
  } state_e;

  // Mid-scale bias of an unsigned chroma sample of width w.
  function automatic int chroma_offset(input int w);
    return 128 << (w - 8);
  endfunction

endpackage

// File: rtl/yuv422_standard2yuv_chroma_unoffset.sv
// Converts one unsigned offset-binary chroma sample to two's complement.
import yuv422_standard2yuv_pkg::*;

module yuv422_standard2yuv_chroma_unoffset #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [PIXEL_WIDTH-1:0] sample,
  output logic [PIXEL_WIDTH-1:0] signed_sample
);

  // Modulo subtraction of the mid-scale bias reduces to flipping the MSB.
  assign signed_sample = sample - PIXEL_WIDTH'(chroma_offset(PIXEL_WIDTH));

endmodule

// File: rtl/yuv422_standard2yuv.sv
// Unpacks an interleaved unsigned 4:2:2 stream into one signed-chroma 4:4:4
// pixel per luma sample, with a registered bypass when enable is low.
import yuv422_standard2yuv_pkg::*;

module yuv422_standard2yuv #(
  parameter int PIXEL_WIDTH = 8,
  parameter bit SWAP_UV     = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [PIXEL_WIDTH-1:0]  datai,
  input  logic [META_WIDTH-1:0]   meta_datai,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0]  yo,
  output logic [PIXEL_WIDTH-1:0]  uo,
  output logic [PIXEL_WIDTH-1:0]  vo,
  output logic [META_WIDTH-1:0]   meta_datao,
  output logic                    align_err
);

  state_e                 state, state_nxt;
  logic [PIXEL_WIDTH-1:0] c0_hold, c0_nxt;
  logic [PIXEL_WIDTH-1:0] y0_hold, y0_nxt;
  logic [PIXEL_WIDTH-1:0] u_hold, u_nxt, v_hold, v_nxt;
  logic [PIXEL_WIDTH-1:0] u_raw, v_raw, u_new, v_new;
  logic [PIXEL_WIDTH-1:0] y_sel, u_sel, v_sel;
  logic                   emit, err_set;

  // c0_hold is always the first chroma of the group; SWAP_UV says which one that is.
  assign u_raw = SWAP_UV ? datai : c0_hold;
  assign v_raw = SWAP_UV ? c0_hold : datai;

  yuv422_standard2yuv_chroma_unoffset #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_unoffset_u (
    .sample        (u_raw),
    .signed_sample (u_new)
  );

  yuv422_standard2yuv_chroma_unoffset #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_unoffset_v (
    .sample        (v_raw),
    .signed_sample (v_new)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    c0_nxt    = c0_hold;
    y0_nxt    = y0_hold;
    u_nxt     = u_hold;
    v_nxt     = v_hold;
    emit      = 1'b0;
    err_set   = 1'b0;
    y_sel     = datai;
    u_sel     = u_hold;
    v_sel     = v_hold;
    if (!enable) begin
      state_nxt = S_C0;
      c0_nxt    = '0;
      y0_nxt    = '0;
      u_nxt     = '0;
      v_nxt     = '0;
    end else begin
      unique case (state)
        S_C0: if (dvi) begin
          c0_nxt    = datai;
          state_nxt = S_Y0;
        end
        S_Y0: if (dvi) begin
          y0_nxt    = datai;
          state_nxt = S_C1;
        end else begin
          state_nxt = S_C0;
          err_set   = 1'b1;
        end
        S_C1: if (dvi) begin
          emit      = 1'b1;
          y_sel     = y0_hold;
          u_sel     = u_new;
          v_sel     = v_new;
          u_nxt     = u_new;
          v_nxt     = v_new;
          state_nxt = S_Y1;
        end else begin
          state_nxt = S_C0;
          err_set   = 1'b1;
        end
        S_Y1: if (dvi) begin
          emit      = 1'b1;
          state_nxt = S_C0;
        end
        default: state_nxt = S_C0;
      endcase
    end
  end

  // NOTE: holding registers are reset too, so a group cut by reset leaves no stale chroma.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= S_C0;
      c0_hold <= '0;
      y0_hold <= '0;
      u_hold  <= '0;
      v_hold  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_nxt;
      c0_hold <= c0_nxt;
      y0_hold <= y0_nxt;
      u_hold  <= u_nxt;
      v_hold  <= v_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dvo        <= 1'b0;
      dtypeo     <= '0;
      yo         <= '0;
      uo         <= '0;
      vo         <= '0;
      meta_datao <= '0;
      align_err  <= 1'b0;
    end else if (!enable) begin
      dvo        <= dvi;
      dtypeo     <= dtypei;
      yo         <= datai;
      uo         <= '0;
      vo         <= '0;
      meta_datao <= meta_datai;
      align_err  <= 1'b0;
    end else begin
      dvo <= emit;
      if (emit) begin
        dtypeo     <= dtypei;
        yo         <= y_sel;
        uo         <= u_sel;
        vo         <= v_sel;
        meta_datao <= meta_datai;
      end
      if (err_set) align_err <= 1'b1;
    end
  end

endmodule

// File: doc/yuv422_standard2yuv.md
Name: yuv422_standard2yuv

Overview:
- Inverse of the standard-format YUV stage: accepts an interleaved unsigned 4:2:2 byte stream (U0 Y0 V0 Y1 …) from the sensor/readback path.
- Removes the chroma offset so U/V become signed.
- Reconstructs one 4:4:4 pixel (y, u, v) per luma sample.
- Sits in front of the signed-YUV processing stages (colour matrix, scaler); dtype/meta pass through with the pixel.

Parameters:
- PIXEL_WIDTH, 8: width of each input sample and of each output component.
- SWAP_UV, 0: 0 = input order U,Y,V,Y (UYVY); 1 = input order V,Y,U,Y (VYUY). Output u/v are always true U/V.

Ports:
- clk  in  1  clock.
- resetb  in  1  asynchronous, active-low reset.
- enable  in  1  1 = convert/unpack; 0 = bypass.
- dvi  in  1  input sample valid.
- dtypei  in  `DTYPE_WIDTH  data type tag of the input beat.
- datai  in  PIXEL_WIDTH  interleaved unsigned sample.
- meta_datai  in  16  metadata of the input beat.
- dvo  out  1  output pixel valid.
- dtypeo  out  `DTYPE_WIDTH  tag of the beat that completed the pixel.
- yo  out  PIXEL_WIDTH  luma, unsigned.
- uo  out  PIXEL_WIDTH  signed Cb.
- vo  out  PIXEL_WIDTH  signed Cr.
- meta_datao  out  16  metadata of the completing beat.
- align_err  out  1  sticky: partial 4:2:2 group discarded.

Behaviour:
- Reset (async, resetb low): every output register is 0, the FSM goes to S_C0 and the holding registers are cleared. This applies mid-group as well; a partial group is lost without setting align_err.
- Offset removal: signed = unsigned − (128 << (PIXEL_WIDTH−8)), computed modulo 2^PIXEL_WIDTH (equivalent to inverting the MSB). Example: 0x80 → 0, 0xFF → +127, 0x00 → −128.
- FSM states and transitions (advance only on dvi=1):
  - S_C0: capture first chroma into c0_hold, go to S_Y0.
  - S_Y0: capture y0_hold, go to S_C1.
  - S_C1: emit pixel0 = (y0_hold, U, V), where the chroma pair is c0_hold plus the current sample (routed by SWAP_UV). Store the pair in uv_hold. Go to S_Y1.
  - S_Y1: emit pixel1 = (datai, uv_hold), go to S_C0.
- Emit means that on the next clk edge: dvo=1, yo/uo/vo are updated, and dtypeo/meta_datao take the current beat's dtypei/meta_datai.
  - Latency: pixel0 appears 1 cycle after the C1 beat; pixel1 appears 1 cycle after the Y1 beat.
  - Rate: at most 1 output per cycle; no backpressure is required.
- dvo=0 cycles: dvo<=0. yo/uo/vo/dtypeo/meta_datao hold their last values.
- Line gap, dvi=0:
  - In S_C0 or S_Y1: state is held (S_Y1 keeps uv_hold and waits for Y1).
  - In S_Y0 or S_C1: the partial group is discarded, state returns to S_C0 and align_err is set to 1. A dvi=0 gap arriving after C1 is legal.
- align_err is sticky. It clears only on reset or on any cycle with enable=0.
- enable=0 (bypass):
  - Each cycle: dvo<=dvi, dtypeo<=dtypei, meta_datao<=meta_datai, yo<=datai, uo<=0, vo<=0.
  - FSM is forced to S_C0 and holding registers are cleared.
  - Latency is 1 cycle.
- enable toggling mid-group: falling to 0 aborts the group (no error flag). Rising to 1 starts the FSM in S_C0 on the next beat.

Decomposition:
- Shared package (dtypes/imager defines): CHROMA_OFFSET(w) = 128 << (w−8); FSM state encodings S_C0/S_Y0/S_C1/S_Y1 (2-bit).
- Optional sub-module: chroma_unoffset (combinational MSB-invert of one sample, PIXEL_WIDTH parameter). It is instantiated twice; everything else stays in the top module.

Test Plan:
- Reset/idle: hold resetb low with toggling inputs → all outputs 0 and align_err 0. Release → dvo stays 0 until a full C0,Y0,C1 sequence arrives.
- Basic UYVY: enable=1, contiguous beats 0x90,0x40,0x70,0x50 → cycle t2+1: dvo=1, y=0x40, u=+16, v=−16. Cycle t3+1: dvo=1, y=0x50, u=+16, v=−16. Each output carries the dtype/meta of its completing beat.
- Extremes and SWAP_UV: SWAP_UV=1, beats 0x00,0x10,0xFF,0x20 → u=+127, v=−128 on both pixels. With PIXEL_WIDTH=10, beat 0x200 → 0.
- Line gap: dvi drops after U0,Y0 → no output and align_err=1. Next full group decodes correctly. Pulsing enable=0 for 1 cycle clears align_err.
- Legal gap: 3 idle cycles between V0 and Y1 → pixel1 is emitted with the held u/v and align_err stays 0.
- Bypass/reset mid-op: enable=0 streams 0x11,0x22 → yo follows with 1-cycle lag, uo=vo=0. Asserting resetb low between C0 and Y0 → outputs zero and the next group decodes from S_C0.
